rcs_pipe_clk: RTL
=================

// Module: rcs_pipe_clk
// PURPOSE
//  Pipelined WIDTH-bit ripple-borrow subtractor with registered I/O: D = A - B - BI.
//  It is the subtract counterpart of the registered ripple-carry adder in the CLA datapath.
//  The subtraction is sliced into STAGES pipeline segments, so one operand pair is accepted every cycle.
//  Accepted pairs are tracked by a valid bit, and the whole pipe can be stalled.
//  The block feeds the ALU result mux alongside the adder.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be divisible by STAGES
//  STAGES   4  pipeline segments; each segment resolves WIDTH/STAGES bits (8 at default)
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  en         in   1      pipeline advance enable; 0 = every register holds
//  in_valid   in   1      a/b/bi carry a new operand pair this cycle
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bi         in   1      borrow in
//  out_valid  out  1      d/bo/ov carry a completed result
//  d          out  WIDTH  difference, a - b - bi, modulo 2^WIDTH
//  bo         out  1      borrow out; 1 iff unsigned a < b + bi
//  ov         out  1      signed overflow: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB])
// BEHAVIOUR
//  - Reset, sampled on a clock edge with reset=1:
//      all stage registers, out_valid, d, bo and ov go to 0.
//      reset has priority over en.
//  - en=1 at an edge, pipe advances:
//      stage 0 captures a, b, bi and in_valid.
//      stage i computes slice i of the difference, using the registered borrow from stage i-1.
//      stage i forwards, delayed, the not-yet-processed upper operand slices and the finished lower difference slices.
//  - Latency: a pair sampled at edge k appears on d/bo/ov with out_valid=1 after edge k+STAGES, provided en=1 on every intervening edge.
//  - en=0 at an edge:
//      no register changes, including the outputs.
//      inputs presented that cycle are ignored; no pair is lost or duplicated.
//  - Throughput: one result per enabled cycle. There is no backpressure; the consumer must accept every out_valid.
//  - in_valid=0 inserts a bubble that travels the pipe; the output shows out_valid=0 for that slot.
//  - d/bo/ov are don't-care when out_valid=0, but they must not be X after reset.
//  - Results leave strictly in input order.
//  - ov is derived from the MSBs of a and b carried through the pipe and the final d[MSB].
//  - bo is the borrow out of the top slice.
//  - Reset mid-stream: all in-flight pairs are discarded, and no stale result emerges afterwards.
//  - Wrap-around: 0 - 1 gives d = all ones with bo=1; no saturation.
// TESTING (WIDTH=32, STAGES=4, en=1 unless stated)
//  1 a=0, b=0, bi=0, in_valid pulse -> exactly 4 edges later: out_valid=1, d=0x00000000, bo=0, ov=0.
//  2 a=0x00000000, b=0x00000001, bi=0 -> d=0xFFFFFFFF, bo=1, ov=0.
//  3 a=0x135FA562, b=0x35614642:
//      bi=0 -> d=0xDDFE5F20, bo=1, ov=0.
//      next cycle bi=1 -> d=0xDDFE5F1F, bo=1, ov=0.
//  4 a=0x80000000, b=0x00000001, bi=0 -> d=0x7FFFFFFF, bo=0, ov=1.
//  5 Four back-to-back pairs with en dropped for 2 cycles mid-stream:
//      results come out in order; outputs are frozen while en=0; total latency grows by exactly 2.
//  6 Reset asserted for 1 cycle with 2 pairs in flight:
//      next edge gives out_valid=0 and d=0.
//      no out_valid for those pairs appears on any later cycle.
//  All cases: scoreboard compares against the model {bo,d} = {1'b0,a} - {1'b0,b} - bi.

Source files
------------

// File: rtl/rcs_pipe_clk_if.sv
// Operand/result bundle for the pipelined ripple-borrow subtractor.
// The producer uses the master modport; the subtractor uses the slave modport.
interface rcs_pipe_clk_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             out_valid;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ov;

  modport master (
    output en, in_valid, a, b, bi,
    input  out_valid, d, bo, ov
  );

  modport slave (
    input  en, in_valid, a, b, bi,
    output out_valid, d, bo, ov
  );
endinterface

// File: rtl/rcs_pipe_clk.sv
// Pipelined WIDTH-bit ripple-borrow subtractor, d = a - b - bi, one slice per stage.
// Stage 0 registers the operands; each later edge resolves one slice; results leave after STAGES edges.
module rcs_pipe_clk #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic           clock,
  input logic           reset,
  rcs_pipe_clk_if.slave bus
);
  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage state. x holds finished difference slices on top and the
  // unprocessed minuend slices below, rotated so the slice being worked on
  // always sits in bits [SW-1:0]; y rotates the subtrahend the same way.
  logic             v_q  [STAGES];
  logic             br_q [STAGES];
  logic [WIDTH-1:0] x_q  [STAGES];
  logic [WIDTH-1:0] y_q  [STAGES];

  // Slice result per stage: bit SW is the borrow out of that slice.
  logic [SW:0]      diff [STAGES];

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      diff[s] = {1'b0, x_q[s][SW-1:0]} - {1'b0, y_q[s][SW-1:0]} - {{SW{1'b0}}, br_q[s]};
    end
  end

  // NOTE: every state element uses non-blocking assignment so all stages
  // sample the values from before the edge and data moves exactly one stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the stage arrays are cleared too, not just the valid bits,
      // so d/bo/ov can never show X and nothing stale survives a reset.
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]  <= 1'b0;
        br_q[s] <= 1'b0;
        x_q[s]  <= '0;
        y_q[s]  <= '0;
      end
      bus.out_valid <= 1'b0;
      bus.d         <= '0;
      bus.bo        <= 1'b0;
      bus.ov        <= 1'b0;
    end else if (bus.en) begin
      v_q[0]  <= bus.in_valid;
      br_q[0] <= bus.bi;
      x_q[0]  <= bus.a;
      y_q[0]  <= bus.b;
      for (int s = 1; s < STAGES; s++) begin
        v_q[s]  <= v_q[s-1];
        br_q[s] <= diff[s-1][SW];
        x_q[s]  <= {diff[s-1][SW-1:0], x_q[s-1][WIDTH-1:SW]};
        y_q[s]  <= {y_q[s-1][SW-1:0], y_q[s-1][WIDTH-1:SW]};
      end
      // In the last stage the top operand slices sit at [SW-1:0], so their
      // MSBs are the operand sign bits needed for overflow.
      bus.out_valid <= v_q[LAST];
      bus.d         <= {diff[LAST][SW-1:0], x_q[LAST][WIDTH-1:SW]};
      bus.bo        <= diff[LAST][SW];
      bus.ov        <= (x_q[LAST][SW-1] != y_q[LAST][SW-1]) &&
                       (diff[LAST][SW-1] != x_q[LAST][SW-1]);
    end
  end
endmodule
